// File: rtl/pe_skew_feeder.sv
// Buffers one tile of activation vectors from a valid/ready stream.
// It then replays the tile into the PE rows with row r delayed r cycles.
module pe_skew_feeder #(
  parameter int ROWS  = 4,
  parameter int I_X   = 8,
  parameter int DEPTH = 16,
  parameter int LW    = 5
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [LW-1:0]       i_len,
  input  logic [ROWS*I_X-1:0] i_data,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [ROWS*I_X-1:0] o_x,
  output logic [ROWS-1:0]     o_xvalid,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(DEPTH + ROWS) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SKEW = 2'd2} state_t;

  state_t state, state_nxt;

  logic [ROWS*I_X-1:0] buffer [DEPTH];
  logic [LW-1:0]       len, wcnt;
  logic [TW-1:0]       t, t_last;
  logic [TW-1:0]       k [ROWS];
  logic                len_legal, start_ok, beat, last_beat, last_step;

  logic signed [I_X-1:0] x_p0 [ROWS];
  logic [ROWS-1:0]       vld_p0;
  logic signed [I_X-1:0] x_p1 [ROWS];
  logic [ROWS-1:0]       vld_p1;
  logic                  done_p1, err_p1;

  function automatic logic signed [I_X-1:0] lane_of(input logic [ROWS*I_X-1:0] vec,
                                                    input int r);
    return vec[r*I_X +: I_X];
  endfunction

  always_comb begin
    len_legal = (i_len != '0) && (i_len <= LW'(DEPTH));
    // The o_done cycle still counts as busy, so a start there is ignored.
    start_ok  = (state == IDLE) && !done_p1 && i_start;
    beat      = (state == LOAD) && i_valid;
    last_beat = beat && (wcnt == len - LW'(1));
    t_last    = TW'(len) + TW'(ROWS - 2);
    last_step = (state == SKEW) && (t == t_last);
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok && len_legal) state_nxt = LOAD;
      LOAD:    if (last_beat) state_nxt = SKEW;
      SKEW:    if (last_step) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Stage p0: lane r of step t reads vector t-r when it lies inside the tile
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      k[r]      = t - TW'(r);
      vld_p0[r] = (state == SKEW) && (t >= TW'(r)) && (k[r] < TW'(len));
      x_p0[r]   = vld_p0[r] ? lane_of(buffer[k[r][AW-1:0]], r) : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      len     <= '0;
      wcnt    <= '0;
      t       <= '0;
      vld_p1  <= '0;
      done_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      err_p1  <= start_ok && !len_legal;
      done_p1 <= last_step;
      vld_p1  <= vld_p0;
      if (start_ok && len_legal) begin
        len  <= i_len;
        wcnt <= '0;
      end else if (beat) begin
        wcnt <= wcnt + LW'(1);
      end
      if (state == SKEW) t <= t + TW'(1);
      else               t <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (beat) buffer[wcnt[AW-1:0]] <= i_data;
    for (int r = 0; r < ROWS; r++) x_p1[r] <= x_p0[r];
  end

  // Stage p1: data regs carry no reset; the registered valid masks them to zero
  always_comb begin
    o_x = '0;
    for (int r = 0; r < ROWS; r++)
      o_x[r*I_X +: I_X] = vld_p1[r] ? x_p1[r] : '0;
  end

  assign o_xvalid = vld_p1;
  assign o_done   = done_p1;
  assign o_err    = err_p1;
  assign o_ready  = (state == LOAD);
  assign o_busy   = (state != IDLE) || done_p1;

endmodule

// File: tb/tb_pe_skew_feeder.sv
// Randomized self-checking bench for pe_skew_feeder against a tile/skew reference model.
module tb_pe_skew_feeder;

  localparam int ROWS  = 4;
  localparam int I_X   = 8;
  localparam int DEPTH = 16;
  localparam int LW    = 5;
  localparam int W     = ROWS * I_X;
  localparam int MAXW  = DEPTH + ROWS + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] len_in;
  logic [W-1:0]  data;
  logic          valid;
  logic          ready;
  logic [W-1:0]  x;
  logic [ROWS-1:0] xvalid;
  logic          busy, done, err;

  always #5 clk = ~clk;

  pe_skew_feeder #(.ROWS(ROWS), .I_X(I_X), .DEPTH(DEPTH), .LW(LW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len_in), .i_data(data),
    .i_valid(valid), .o_ready(ready), .o_x(x), .o_xvalid(xvalid),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  int errors = 0;
  int checks = 0;
  bit noise  = 1'b0;

  logic [W-1:0]    tile      [DEPTH];
  logic [W-1:0]    obs_x     [MAXW];
  logic [ROWS-1:0] obs_v     [MAXW];
  logic            obs_done  [MAXW];
  logic            obs_busy  [MAXW];
  logic            obs_ready [MAXW];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: d cycles after the edge taking the last beat, lane r carries vector d-1-r.
  function automatic logic [W-1:0] exp_x(input int d, input int n);
    logic [W-1:0] v;
    int kk;
    v = '0;
    for (int r = 0; r < ROWS; r++) begin
      kk = d - 1 - r;
      if (kk >= 0 && kk < n) v[r*I_X +: I_X] = tile[kk][r*I_X +: I_X];
    end
    return v;
  endfunction

  function automatic logic [ROWS-1:0] exp_v(input int d, input int n);
    logic [ROWS-1:0] m;
    int kk;
    m = '0;
    for (int r = 0; r < ROWS; r++) begin
      kk = d - 1 - r;
      if (kk >= 0 && kk < n) m[r] = 1'b1;
    end
    return m;
  endfunction

  // Loads tile[0..n-1] with `gap` idle cycles between beats, then records the output window.
  // With abort_d >= 0, reset is pulsed at that point of the window and the task returns.
  task automatic drive_tile(input int n, input int gap, input int abort_d);
    start = 1'b1; len_in = LW'(n); valid = 1'b0; data = W'($urandom);
    step();
    start = 1'b0;
    for (int b = 0; b < n; b++) begin
      for (int g = 0; g < ((b == 0) ? 0 : gap); g++) begin
        valid = 1'b0; data = W'($urandom);
        if (noise) begin start = 1'($urandom); len_in = LW'($urandom); end
        step();
      end
      valid = 1'b1; data = tile[b];
      if (noise) begin start = 1'($urandom); len_in = LW'($urandom); end
      step();
    end
    valid = 1'b0; start = 1'b0;
    for (int d = 0; d <= n + ROWS; d++) begin
      obs_x[d] = x; obs_v[d] = xvalid; obs_done[d] = done;
      obs_busy[d] = busy; obs_ready[d] = ready;
      if (d == abort_d) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        return;
      end
      if (d < n + ROWS) begin
        if (noise) begin
          start = 1'($urandom); len_in = LW'($urandom);
          valid = 1'($urandom); data = W'($urandom);
        end
        step();
      end
    end
    start = 1'b0; valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom); len_in = LW'($urandom);
      valid = 1'($urandom); data = W'($urandom);
      step();
    end
    rst = 1'b0; start = 1'b0; valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (x !== '0) begin errors++; $display("FAIL reset_x got=%h exp=0", x); end
      checks++; if (xvalid !== '0) begin errors++; $display("FAIL reset_xvalid got=%b exp=0", xvalid); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      step();
    end
  endtask

  task automatic test_basic();
    int n = 3;
    for (int k = 0; k < n; k++)
      for (int r = 0; r < ROWS; r++) tile[k][r*I_X +: I_X] = I_X'(16*k + r);
    noise = 1'b0;
    drive_tile(n, 0, -1);
    for (int d = 0; d <= n + ROWS; d++) begin
      checks++; if (obs_x[d] !== exp_x(d, n)) begin errors++; $display("FAIL basic_x d=%0d got=%h exp=%h", d, obs_x[d], exp_x(d, n)); end
      checks++; if (obs_v[d] !== exp_v(d, n)) begin errors++; $display("FAIL basic_xvalid d=%0d got=%b exp=%b", d, obs_v[d], exp_v(d, n)); end
      checks++; if (obs_done[d] !== (d == n + ROWS - 1)) begin errors++; $display("FAIL basic_done d=%0d got=%b", d, obs_done[d]); end
      checks++; if (obs_busy[d] !== (d <= n + ROWS - 1)) begin errors++; $display("FAIL basic_busy d=%0d got=%b", d, obs_busy[d]); end
      checks++; if (obs_ready[d] !== 1'b0) begin errors++; $display("FAIL basic_ready d=%0d got=%b exp=0", d, obs_ready[d]); end
    end
    checks++; if (obs_x[3][0 +: I_X] !== 8'd32) begin errors++; $display("FAIL basic_lane0_v2 got=%0d exp=32", obs_x[3][0 +: I_X]); end
    checks++; if (obs_x[6][3*I_X +: I_X] !== 8'd35) begin errors++; $display("FAIL basic_lane3_v2 got=%0d exp=35", obs_x[6][3*I_X +: I_X]); end
  endtask

  task automatic test_gaps();
    int n = 4;
    for (int k = 0; k < n; k++) tile[k] = W'($urandom);
    noise = 1'b0;
    drive_tile(n, 3, -1);
    for (int d = 0; d <= n + ROWS; d++) begin
      checks++; if (obs_x[d] !== exp_x(d, n)) begin errors++; $display("FAIL gaps_x d=%0d got=%h exp=%h", d, obs_x[d], exp_x(d, n)); end
      checks++; if (obs_v[d] !== exp_v(d, n)) begin errors++; $display("FAIL gaps_xvalid d=%0d got=%b exp=%b", d, obs_v[d], exp_v(d, n)); end
      checks++; if (obs_done[d] !== (d == n + ROWS - 1)) begin errors++; $display("FAIL gaps_done d=%0d got=%b", d, obs_done[d]); end
      checks++; if (obs_busy[d] !== (d <= n + ROWS - 1)) begin errors++; $display("FAIL gaps_busy d=%0d got=%b", d, obs_busy[d]); end
    end
  endtask

  task automatic test_full_depth();
    int n = DEPTH;
    int window = 0;
    for (int k = 0; k < n; k++)
      for (int r = 0; r < ROWS; r++) tile[k][r*I_X +: I_X] = I_X'(-128 + k);
    noise = 1'b0;
    drive_tile(n, 0, -1);
    for (int d = 0; d <= n + ROWS; d++) begin
      if (obs_v[d] != '0) window++;
      checks++; if (obs_x[d] !== exp_x(d, n)) begin errors++; $display("FAIL full_x d=%0d got=%h exp=%h", d, obs_x[d], exp_x(d, n)); end
      checks++; if (obs_v[d] !== exp_v(d, n)) begin errors++; $display("FAIL full_xvalid d=%0d got=%b exp=%b", d, obs_v[d], exp_v(d, n)); end
      checks++; if (obs_done[d] !== (d == n + ROWS - 1)) begin errors++; $display("FAIL full_done d=%0d got=%b", d, obs_done[d]); end
      checks++; if (obs_busy[d] !== (d <= n + ROWS - 1)) begin errors++; $display("FAIL full_busy d=%0d got=%b", d, obs_busy[d]); end
    end
    checks++; if (window != 19) begin errors++; $display("FAIL full_window got=%0d exp=19", window); end
  endtask

  task automatic test_illegal();
    int bad [2] = '{0, 17};
    for (int i = 0; i < 2; i++) begin
      start = 1'b1; len_in = LW'(bad[i]);
      step();
      start = 1'b0;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err len=%0d got=%b exp=1", bad[i], err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL illegal_busy len=%0d got=%b exp=0", bad[i], busy); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL illegal_ready len=%0d got=%b exp=0", bad[i], ready); end
      step();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL illegal_err_pulse len=%0d got=%b exp=0", bad[i], err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL illegal_busy2 len=%0d got=%b exp=0", bad[i], busy); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    noise = 1'b1;
    for (int it = 0; it < 6; it++) begin
      n = (it == 0) ? 1 : int'($urandom_range(1, DEPTH));
      for (int k = 0; k < n; k++) tile[k] = W'($urandom);
      drive_tile(n, int'($urandom_range(0, 2)), -1);
      for (int d = 0; d <= n + ROWS; d++) begin
        checks++; if (obs_x[d] !== exp_x(d, n)) begin errors++; $display("FAIL b2b_x it=%0d d=%0d got=%h exp=%h", it, d, obs_x[d], exp_x(d, n)); end
        checks++; if (obs_v[d] !== exp_v(d, n)) begin errors++; $display("FAIL b2b_xvalid it=%0d d=%0d got=%b exp=%b", it, d, obs_v[d], exp_v(d, n)); end
        checks++; if (obs_done[d] !== (d == n + ROWS - 1)) begin errors++; $display("FAIL b2b_done it=%0d d=%0d got=%b", it, d, obs_done[d]); end
        checks++; if (obs_busy[d] !== (d <= n + ROWS - 1)) begin errors++; $display("FAIL b2b_busy it=%0d d=%0d got=%b", it, d, obs_busy[d]); end
      end
    end
    noise = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n = 5;
    int dones = 0;
    for (int k = 0; k < n; k++) tile[k] = W'($urandom);
    noise = 1'b0;
    drive_tile(n, 0, 2);
    checks++; if (x !== '0) begin errors++; $display("FAIL abort_x got=%h exp=0", x); end
    checks++; if (xvalid !== '0) begin errors++; $display("FAIL abort_xvalid got=%b exp=0", xvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b exp=0", ready); end
    for (int i = 0; i < n + ROWS; i++) begin
      if (done === 1'b1 || xvalid !== '0) dones++;
      step();
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    n = 2;
    for (int k = 0; k < n; k++) tile[k] = W'($urandom);
    drive_tile(n, 0, -1);
    for (int d = 0; d <= n + ROWS; d++) begin
      checks++; if (obs_x[d] !== exp_x(d, n)) begin errors++; $display("FAIL after_abort_x d=%0d got=%h exp=%h", d, obs_x[d], exp_x(d, n)); end
      checks++; if (obs_v[d] !== exp_v(d, n)) begin errors++; $display("FAIL after_abort_xvalid d=%0d got=%b exp=%b", d, obs_v[d], exp_v(d, n)); end
      checks++; if (obs_done[d] !== (d == n + ROWS - 1)) begin errors++; $display("FAIL after_abort_done d=%0d got=%b", d, obs_done[d]); end
      checks++; if (obs_busy[d] !== (d <= n + ROWS - 1)) begin errors++; $display("FAIL after_abort_busy d=%0d got=%b", d, obs_busy[d]); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len_in = '0; data = '0; valid = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_full_depth();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
